// File: rtl/dvi_video_pkg.sv
// Shared video definitions for the DVI path: 640x480@60 timing, the test
// pattern selector and the colour-bar palette.
package dvi_video_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef enum logic [1:0] {
        BARS   = 2'd0,
        GRID   = 2'd1,
        RAMP   = 2'd2,
        MOVING = 2'd3
    } pattern_t;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    // Bars run left to right in the classic descending-luma order.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvi_pattern_gen_if.sv
// Raster/pixel bundle from the pattern generator to the DVI encoder inputs.
interface dvi_pattern_gen_if;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       frame_start;

    modport master (
        output hsync, vsync, de, red, green, blue, hpos, vpos, frame_start
    );

    modport slave (
        input hsync, vsync, de, red, green, blue, hpos, vpos, frame_start
    );
endinterface

// File: rtl/dvi_pattern_rgb.sv
// Combinational test-pattern colour for the raster position held in the
// parent's counters; blanking is applied by the parent.
module dvi_pattern_rgb
    import dvi_video_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int V_ACTIVE = VGA_V_ACTIVE
) (
    input  logic [9:0]  hcnt,
    input  logic [9:0]  vcnt,
    input  logic [7:0]  frame_cnt,
    input  pattern_t    pattern_q,
    output logic [23:0] rgb
);

    localparam logic [9:0] BAR_W  = 10'(H_ACTIVE / 8);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);

    logic [2:0] bar_idx;
    logic       grid_on;
    logic [7:0] blue_mov;

    always_comb begin
        bar_idx  = 3'(hcnt / BAR_W);
        grid_on  = (hcnt[4:0] == 5'd0) || (vcnt[4:0] == 5'd0) ||
                   (hcnt == H_LAST) || (vcnt == V_LAST);
        blue_mov = hcnt[7:0] + frame_cnt;
        rgb      = RGB_BLACK;
        case (pattern_q)
            BARS:    rgb = bar_colour(bar_idx);
            GRID:    rgb = grid_on ? RGB_WHITE : RGB_BLACK;
            RAMP:    rgb = {3{hcnt[9:2]}};
            MOVING:  rgb = {frame_cnt, vcnt[8:1], blue_mov};
            default: rgb = RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/dvi_pattern_gen.sv
// Free-running raster timing plus selectable test pattern in the clk25
// domain; every output is registered one clock after the counters it decodes.
module dvi_pattern_gen
    import dvi_video_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic               clk25,
    input  logic               rstin,
    input  logic               en,
    input  logic [1:0]         pattern,
    dvi_pattern_gen_if.master  vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [7:0]  frame_cnt;
    pattern_t    pattern_q;
    pattern_t    pattern_sel;
    logic        origin;
    logic        active;
    logic        hs_active;
    logic        vs_active;
    logic [23:0] rgb_next;

    // The origin pixel already shows the newly sampled pattern, so a whole
    // frame is always drawn with one selection.
    always_comb begin
        origin      = (hcnt == 10'd0) && (vcnt == 10'd0);
        active      = (hcnt < H_ACT) && (vcnt < V_ACT);
        hs_active   = (hcnt >= HS_START) && (hcnt < HS_END);
        vs_active   = (vcnt >= VS_START) && (vcnt < VS_END);
        pattern_sel = origin ? pattern_t'(pattern) : pattern_q;
    end

    dvi_pattern_rgb #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_rgb (
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .frame_cnt (frame_cnt),
        .pattern_q (pattern_sel),
        .rgb       (rgb_next)
    );

    always_ff @(posedge clk25 or posedge rstin) begin
        if (rstin) begin
            hcnt            <= 10'd0;
            vcnt            <= 10'd0;
            frame_cnt       <= 8'd0;
            pattern_q       <= BARS;
            vid.hsync       <= ~HS_POL;
            vid.vsync       <= ~VS_POL;
            vid.de          <= 1'b0;
            vid.red         <= 8'd0;
            vid.green       <= 8'd0;
            vid.blue        <= 8'd0;
            vid.hpos        <= 10'd0;
            vid.vpos        <= 10'd0;
            vid.frame_start <= 1'b0;
        end else if (!en) begin
            hcnt            <= 10'd0;
            vcnt            <= 10'd0;
            frame_cnt       <= 8'd0;
            pattern_q       <= BARS;
            vid.hsync       <= ~HS_POL;
            vid.vsync       <= ~VS_POL;
            vid.de          <= 1'b0;
            vid.red         <= 8'd0;
            vid.green       <= 8'd0;
            vid.blue        <= 8'd0;
            vid.hpos        <= 10'd0;
            vid.vpos        <= 10'd0;
            vid.frame_start <= 1'b0;
        end else begin
            if (hcnt == H_LAST) begin
                hcnt <= 10'd0;
                if (vcnt == V_LAST) begin
                    vcnt      <= 10'd0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    vcnt <= vcnt + 10'd1;
                end
            end else begin
                hcnt <= hcnt + 10'd1;
            end

            if (origin) begin
                pattern_q <= pattern_t'(pattern);
            end

            vid.hsync       <= hs_active ? HS_POL : ~HS_POL;
            vid.vsync       <= vs_active ? VS_POL : ~VS_POL;
            vid.de          <= active;
            vid.red         <= active ? rgb_next[23:16] : 8'd0;
            vid.green       <= active ? rgb_next[15:8]  : 8'd0;
            vid.blue        <= active ? rgb_next[7:0]   : 8'd0;
            vid.hpos        <= hcnt;
            vid.vpos        <= vcnt;
            vid.frame_start <= origin;
        end
    end

endmodule

// File: tb/tb_dvi_pattern_gen.sv
// Directed bench for dvi_pattern_gen using two shrunken rasters so whole
// frames (and a 257-frame counter wrap) fit in a short run.
module tb_dvi_pattern_gen;

    // Raster A: 64x20 active, 96 clocks/line, 26 lines, 2496 clocks/frame.
    localparam int A_LINE  = 96;
    localparam int A_FRAME = 2496;

    logic       clk25 = 1'b0;
    logic       rstin;
    logic       en;
    logic [1:0] pattern;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int          bar_x   [10] = '{0, 8, 16, 24, 32, 40, 48, 56, 63, 64};
    logic [23:0] bar_rgb [10] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000,
                                  24'h000000, 24'h000000};

    int          grid_x   [8] = '{5, 0, 5, 63, 32, 31, 7, 7};
    int          grid_y   [8] = '{0, 1, 1, 1, 2, 18, 18, 19};
    logic [23:0] grid_rgb [8] = '{24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'hFFFFFF,
                                  24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF};

    dvi_pattern_gen_if vid_a ();
    dvi_pattern_gen_if vid_b ();

    dvi_pattern_gen #(
        .H_ACTIVE (64), .H_FP (8), .H_SYNC (12), .H_BP (12),
        .V_ACTIVE (20), .V_FP (2), .V_SYNC (2),  .V_BP (2),
        .HS_POL (1'b0), .VS_POL (1'b0)
    ) dut_a (
        .clk25   (clk25),
        .rstin   (rstin),
        .en      (en),
        .pattern (pattern),
        .vid     (vid_a)
    );

    // Raster B: 12x5 = 60 clocks/frame, active-high syncs.
    dvi_pattern_gen #(
        .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (2), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL (1'b1), .VS_POL (1'b1)
    ) dut_b (
        .clk25   (clk25),
        .rstin   (rstin),
        .en      (en),
        .pattern (pattern),
        .vid     (vid_b)
    );

    always #20 clk25 = ~clk25;

    always @(posedge clk25) cyc <= cyc + 1;

    task automatic wait_pixel_a(input int x, input int y, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 3 * A_FRAME && !hit; i++) begin
            @(negedge clk25);
            if (vid_a.hpos == 10'(x) && vid_a.vpos == 10'(y)) hit = 1'b1;
        end
        if (!hit) begin
            tests++;
            fails++;
            $display("[TB] FAIL wait_%s: pixel (%0d,%0d) never reached", tag, x, y);
        end
    endtask

    task automatic wait_fs_a(input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 2 * A_FRAME && !hit; i++) begin
            @(negedge clk25);
            if (vid_a.frame_start === 1'b1) hit = 1'b1;
        end
        if (!hit) begin
            tests++;
            fails++;
            $display("[TB] FAIL wait_%s: no frame_start on A", tag);
        end
    endtask

    task automatic test_reset;
        rstin   = 1'b1;
        en      = 1'b1;
        pattern = 2'd0;
        repeat (3) @(negedge clk25);
        tests++;
        if (vid_a.hsync !== 1'b1 || vid_a.vsync !== 1'b1 || vid_a.de !== 1'b0 ||
            vid_a.frame_start !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl_a: hs=%b vs=%b de=%b fs=%b, want 1 1 0 0",
                     vid_a.hsync, vid_a.vsync, vid_a.de, vid_a.frame_start);
        end
        tests++;
        if ({vid_a.red, vid_a.green, vid_a.blue} !== 24'h0 || vid_a.hpos !== 10'd0 ||
            vid_a.vpos !== 10'd0) begin
            fails++;
            $display("[TB] FAIL reset_data_a: rgb=%h pos=(%0d,%0d), want 000000 (0,0)",
                     {vid_a.red, vid_a.green, vid_a.blue}, vid_a.hpos, vid_a.vpos);
        end
        tests++;
        if (vid_b.hsync !== 1'b0 || vid_b.vsync !== 1'b0 || vid_b.de !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl_b: hs=%b vs=%b de=%b, want 0 0 0",
                     vid_b.hsync, vid_b.vsync, vid_b.de);
        end
        rstin = 1'b0;
        @(negedge clk25);
        tests++;
        if (vid_a.de !== 1'b1 || vid_a.frame_start !== 1'b1 || vid_a.hpos !== 10'd0 ||
            vid_a.vpos !== 10'd0) begin
            fails++;
            $display("[TB] FAIL first_pixel: de=%b fs=%b pos=(%0d,%0d), want 1 1 (0,0)",
                     vid_a.de, vid_a.frame_start, vid_a.hpos, vid_a.vpos);
        end
        tests++;
        if ({vid_a.red, vid_a.green, vid_a.blue} !== 24'hFFFFFF) begin
            fails++;
            $display("[TB] FAIL first_rgb: got %h, want ffffff",
                     {vid_a.red, vid_a.green, vid_a.blue});
        end
    endtask

    // Starts on the clock showing pixel (0,0) of frame 0, which is a de rise.
    task automatic test_timing;
        int rise_cyc = cyc, hs_fall_cyc = 0, fs_cyc = cyc;
        logic p_de = 1'b1, p_hs = 1'b1, p_vs = 1'b1;
        int de_rises = 0, hs_falls = 0, vs_falls = 0, fs_cnt = 0, vs_low = 0;
        int line_err = 0, width_err = 0, hs_off_err = 0, hs_w_err = 0;
        int vs_pos_err = 0, de_out_err = 0, fs_err = 0;
        for (int i = 0; i < 2 * A_FRAME; i++) begin
            @(negedge clk25);
            if (vid_a.de && !p_de) begin
                de_rises++;
                if (vid_a.vpos != 10'd0 && cyc - rise_cyc != A_LINE) line_err++;
                rise_cyc = cyc;
            end
            if (!vid_a.de && p_de && cyc - rise_cyc != 64) width_err++;
            if (!vid_a.hsync && p_hs) begin
                hs_falls++;
                hs_fall_cyc = cyc;
                if (vid_a.vpos < 10'd20 && cyc - rise_cyc != 72) hs_off_err++;
            end
            if (vid_a.hsync && !p_hs && cyc - hs_fall_cyc != 12) hs_w_err++;
            if (!vid_a.vsync) vs_low++;
            if (!vid_a.vsync && p_vs) begin
                vs_falls++;
                if (vid_a.vpos != 10'd22 || vid_a.hpos != 10'd0) vs_pos_err++;
            end
            if (vid_a.vsync && !p_vs && (vid_a.vpos != 10'd24 || vid_a.hpos != 10'd0))
                vs_pos_err++;
            if (vid_a.de && (vid_a.vpos >= 10'd20 || vid_a.hpos >= 10'd64)) de_out_err++;
            if (vid_a.frame_start) begin
                fs_cnt++;
                if (cyc - fs_cyc != A_FRAME || !vid_a.de) fs_err++;
                fs_cyc = cyc;
            end
            p_de = vid_a.de;
            p_hs = vid_a.hsync;
            p_vs = vid_a.vsync;
        end
        tests++;
        if (de_rises != 40 || line_err != 0) begin
            fails++;
            $display("[TB] FAIL line_period: rises=%0d bad=%0d, want 40 0", de_rises, line_err);
        end
        tests++;
        if (width_err != 0 || de_out_err != 0) begin
            fails++;
            $display("[TB] FAIL de_width: bad_width=%0d de_in_blank=%0d, want 0 0",
                     width_err, de_out_err);
        end
        tests++;
        if (hs_falls != 52 || hs_off_err != 0 || hs_w_err != 0) begin
            fails++;
            $display("[TB] FAIL hsync: falls=%0d bad_offset=%0d bad_width=%0d, want 52 0 0",
                     hs_falls, hs_off_err, hs_w_err);
        end
        tests++;
        if (vs_falls != 2 || vs_low != 384 || vs_pos_err != 0) begin
            fails++;
            $display("[TB] FAIL vsync: falls=%0d low_clocks=%0d bad_edges=%0d, want 2 384 0",
                     vs_falls, vs_low, vs_pos_err);
        end
        tests++;
        if (fs_cnt != 2 || fs_err != 0) begin
            fails++;
            $display("[TB] FAIL frame_start: count=%0d bad_interval=%0d, want 2 0",
                     fs_cnt, fs_err);
        end
    endtask

    task automatic test_bars;
        pattern = 2'd0;
        wait_pixel_a(0, 5, "bars");
        for (int c = 0; c < A_LINE; c++) begin
            for (int k = 0; k < 10; k++) begin
                if (vid_a.hpos == 10'(bar_x[k])) begin
                    tests++;
                    if ({vid_a.red, vid_a.green, vid_a.blue} !== bar_rgb[k]) begin
                        fails++;
                        $display("[TB] FAIL bar_x%0d: got %h, want %h", bar_x[k],
                                 {vid_a.red, vid_a.green, vid_a.blue}, bar_rgb[k]);
                    end
                end
            end
            if (vid_a.hpos == 10'd64) begin
                tests++;
                if (vid_a.de !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL bar_de_x64: got %b, want 0", vid_a.de);
                end
            end
            @(negedge clk25);
        end
    endtask

    task automatic test_pattern_switch;
        wait_pixel_a(0, 5, "sw_ramp");
        pattern = 2'd2;
        wait_pixel_a(40, 12, "sw_same");
        tests++;
        if ({vid_a.red, vid_a.green, vid_a.blue} !== 24'hFF0000) begin
            fails++;
            $display("[TB] FAIL switch_midframe: got %h, want ff0000",
                     {vid_a.red, vid_a.green, vid_a.blue});
        end
        wait_pixel_a(40, 3, "sw_next");
        tests++;
        if ({vid_a.red, vid_a.green, vid_a.blue} !== 24'h0A0A0A) begin
            fails++;
            $display("[TB] FAIL ramp_x40: got %h, want 0a0a0a",
                     {vid_a.red, vid_a.green, vid_a.blue});
        end
        wait_pixel_a(0, 5, "sw_grid");
        pattern = 2'd1;
        wait_pixel_a(5, 12, "sw_ramp2");
        tests++;
        if ({vid_a.red, vid_a.green, vid_a.blue} !== 24'h010101) begin
            fails++;
            $display("[TB] FAIL ramp_x5: got %h, want 010101",
                     {vid_a.red, vid_a.green, vid_a.blue});
        end
        for (int k = 0; k < 8; k++) begin
            wait_pixel_a(grid_x[k], grid_y[k], "grid");
            tests++;
            if ({vid_a.red, vid_a.green, vid_a.blue} !== grid_rgb[k]) begin
                fails++;
                $display("[TB] FAIL grid_%0d_%0d: got %h, want %h", grid_x[k], grid_y[k],
                         {vid_a.red, vid_a.green, vid_a.blue}, grid_rgb[k]);
            end
        end
    endtask

    task automatic test_enable_reset;
        int bad = 0;
        pattern = 2'd0;
        wait_pixel_a(5, 10, "en_drop");
        en = 1'b0;
        @(negedge clk25);
        tests++;
        if (vid_a.de !== 1'b0 || vid_a.hsync !== 1'b1 || vid_a.vsync !== 1'b1 ||
            vid_a.frame_start !== 1'b0) begin
            fails++;
            $display("[TB] FAIL en_low_ctrl: de=%b hs=%b vs=%b fs=%b, want 0 1 1 0",
                     vid_a.de, vid_a.hsync, vid_a.vsync, vid_a.frame_start);
        end
        tests++;
        if ({vid_a.red, vid_a.green, vid_a.blue} !== 24'h0 || vid_a.hpos !== 10'd0 ||
            vid_a.vpos !== 10'd0) begin
            fails++;
            $display("[TB] FAIL en_low_data: rgb=%h pos=(%0d,%0d), want 000000 (0,0)",
                     {vid_a.red, vid_a.green, vid_a.blue}, vid_a.hpos, vid_a.vpos);
        end
        repeat (9) begin
            @(negedge clk25);
            if (vid_a.de || !vid_a.hsync || !vid_a.vsync || vid_a.hpos != 10'd0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("[TB] FAIL en_low_hold: bad_clocks=%0d, want 0", bad);
        end
        en = 1'b1;
        @(negedge clk25);
        tests++;
        if (vid_a.de !== 1'b1 || vid_a.frame_start !== 1'b1 || vid_a.hpos !== 10'd0 ||
            vid_a.vpos !== 10'd0) begin
            fails++;
            $display("[TB] FAIL en_restart: de=%b fs=%b pos=(%0d,%0d), want 1 1 (0,0)",
                     vid_a.de, vid_a.frame_start, vid_a.hpos, vid_a.vpos);
        end
        wait_pixel_a(80, 22, "rst_point");
        tests++;
        if (vid_a.hsync !== 1'b0 || vid_a.vsync !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sync_active_80_22: hs=%b vs=%b, want 0 0",
                     vid_a.hsync, vid_a.vsync);
        end
        rstin = 1'b1;
        #1;
        tests++;
        if (vid_a.hsync !== 1'b1 || vid_a.vsync !== 1'b1 || vid_a.de !== 1'b0 ||
            vid_a.hpos !== 10'd0) begin
            fails++;
            $display("[TB] FAIL async_reset: hs=%b vs=%b de=%b hpos=%0d, want 1 1 0 0",
                     vid_a.hsync, vid_a.vsync, vid_a.de, vid_a.hpos);
        end
        repeat (2) @(negedge clk25);
        rstin = 1'b0;
        @(negedge clk25);
        tests++;
        if (vid_a.de !== 1'b1 || vid_a.frame_start !== 1'b1 || vid_a.hpos !== 10'd0 ||
            vid_a.vpos !== 10'd0) begin
            fails++;
            $display("[TB] FAIL rst_restart: de=%b fs=%b pos=(%0d,%0d), want 1 1 (0,0)",
                     vid_a.de, vid_a.frame_start, vid_a.hpos, vid_a.vpos);
        end
    endtask

    task automatic test_moving;
        int red_bad = 0;
        int seen = 0;
        pattern = 2'd3;
        rstin = 1'b1;
        @(negedge clk25);
        rstin = 1'b0;
        for (int f = 0; f < 257; f++) begin
            bit hit = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(negedge clk25);
                if (vid_b.frame_start === 1'b1) hit = 1'b1;
            end
            if (hit) begin
                seen++;
                if (vid_b.red !== 8'(f)) begin
                    red_bad++;
                    if (red_bad < 4)
                        $display("[TB] FAIL moving_red_f%0d: got %h, want %h",
                                 f, vid_b.red, 8'(f));
                end
            end
        end
        tests++;
        if (seen != 257 || red_bad != 0) begin
            fails++;
            $display("[TB] FAIL moving_frame_cnt: frames=%0d bad_red=%0d, want 257 0",
                     seen, red_bad);
        end
        rstin = 1'b1;
        @(negedge clk25);
        rstin = 1'b0;
        for (int f = 0; f < 6; f++) wait_fs_a("moving");
        wait_pixel_a(10, 0, "mov_10_0");
        tests++;
        if ({vid_a.red, vid_a.green, vid_a.blue} !== 24'h05000F) begin
            fails++;
            $display("[TB] FAIL moving_f5_x10: got %h, want 05000f",
                     {vid_a.red, vid_a.green, vid_a.blue});
        end
        wait_pixel_a(10, 5, "mov_10_5");
        tests++;
        if ({vid_a.red, vid_a.green, vid_a.blue} !== 24'h05020F) begin
            fails++;
            $display("[TB] FAIL moving_f5_x10_y5: got %h, want 05020f",
                     {vid_a.red, vid_a.green, vid_a.blue});
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_bars();
        test_pattern_switch();
        test_enable_reset();
        test_moving();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(40 * 150000);
        $display("[TB] FAIL watchdog: simulation exceeded 150000 clocks");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/dvi_pattern_gen.md
# dvi_pattern_gen

Video source for the DVI transmit path. It generates 640x480@60 raster timing (hsync, vsync, de) and a selectable 24-bit test pattern in the clk25 domain. Its outputs connect straight to the `blue_din/green_din/red_din/hsync/vsync/de` inputs of `dvi_encoder_top`. It lets a TX port be driven and checked without a live DVI input.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)

Ports:
- clk25  in  1  pixel clock, 25 MHz
- rstin  in  1  reset: asynchronous, active-high
- en  in  1  run enable; low holds the raster at origin, blanked
- pattern  in  2  0 colour bars, 1 grid, 2 grey ramp, 3 moving
- hsync  out  1  horizontal sync, polarity per HS_POL
- vsync  out  1  vertical sync, polarity per VS_POL
- de  out  1  data enable (active video)
- red, green, blue  out  8 each  pixel colour
- hpos  out  10  x of the current output pixel
- vpos  out  10  y of the current output pixel
- frame_start  out  1  one-cycle pulse with pixel (0,0)

## Operation
- Reset values: hsync=~HS_POL, vsync=~VS_POL, de=0, rgb=0, hpos=vpos=0, frame_start=0. Internal hcnt=vcnt=0, frame_cnt=0, pattern_q=0.
- hcnt counts 0..H_TOTAL-1 (H_TOTAL=800), then wraps to 0.
  - vcnt increments at each hcnt wrap and runs 0..V_TOTAL-1 (V_TOTAL=525), then wraps to 0.
  - frame_cnt (8-bit) increments on vcnt wrap and wraps 255->0.
- Region decode:
  - Active: hcnt<H_ACTIVE and vcnt<V_ACTIVE.
  - hsync active: H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync active: V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (490..491), for the whole of each of those lines.
- pattern is sampled into pattern_q only when hcnt=0 and vcnt=0. A mid-frame change takes effect at the next frame.
- Pixel colour; rgb is forced to 0 whenever de=0:
  - 0, bars: 8 bars of H_ACTIVE/8 pixels each, in order white, yellow, cyan, green, magenta, red, blue, black. Each component is 0x00 or 0xFF.
  - 1, grid: white if hcnt[4:0]==0 or vcnt[4:0]==0 or hcnt==H_ACTIVE-1 or vcnt==V_ACTIVE-1; otherwise black.
  - 2, ramp: red=green=blue=hcnt[9:2] (truncated).
  - 3, moving: red=frame_cnt, green=vcnt[8:1], blue=hcnt[7:0]+frame_cnt (mod 256).
- en low:
  - On the next clock, hcnt, vcnt and frame_cnt clear to 0.
  - Outputs take their reset values.
  - When en rises, the first clock emits pixel (0,0) with frame_start=1, and pattern is sampled on that clock.
- Reset mid-frame behaves the same as en low, applied immediately and asynchronously.

## Timing
- All outputs are registered and launched together, one clock after the counter state they decode (latency 1). hpos/vpos always name the pixel currently on rgb.
- Line period is 800 clocks. de is high for 640 consecutive clocks per active line. hsync asserts 656 clocks after de rises and lasts 96 clocks.
- Frame period is 420000 clocks. de is low for all of lines 480..524. vsync edges coincide with the hpos=0 clock of lines 490 and 492.
- frame_start is high for exactly one clock per frame, on the same clock as the first de=1 of the frame.
- No handshake: the downstream encoder consumes every clock.

## Structure
- Shared package `dvi_video_pkg`:
  - 640x480 timing constants and derived H_TOTAL/V_TOTAL.
  - pattern_t enum (BARS, GRID, RAMP, MOVING).
  - 24-bit colour constants for the eight bars.
- One sub-module, `dvi_pattern_rgb`: combinational colour generator. Inputs: hcnt, vcnt, frame_cnt, pattern_q. Output: 24-bit rgb. The parent owns the counters and the output registers.

## Test plan
- Reset, then release with en=1 -> all outputs at reset values during reset; first clock after release has de=1, hpos=0, vpos=0, frame_start=1.
- Free run for 2 frames, pattern=0 -> measured line = 800 clocks; de width = 640; hsync low for 96 clocks starting 656 after de rise; vsync low on lines 490-491 only; frame_start interval = 420000 clocks.
- Bars -> rgb=FFFFFF at x=0, FFFF00 at x=80, 00FFFF at x=160, 000000 at x=639; rgb=0 at x=640.
- pattern changed 0->2 at line 100 -> rest of frame stays bars; next frame at x=400 gives rgb=646464.
- pattern=3 for 257 frames -> red at (0,0) follows 00,01,...,FF,00; blue at x=10 in frame 5 is 0F.
- en dropped at line 200 for 10 clocks, then rstin pulsed at line 300 -> de=0 and syncs inactive while en is low or reset is asserted; the raster restarts at (0,0) with frame_start=1 after each event.
